// File: rtl/seq_alu_pkg.sv
// Shared opcode encodings, FSM state type and flag vector for seq_alu.
package seq_alu_pkg;

    localparam logic [3:0] OP_TFR  = 4'h0;
    localparam logic [3:0] OP_INC  = 4'h1;
    localparam logic [3:0] OP_DEC  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_ASR  = 4'hB;
    localparam logic [3:0] OP_RLC  = 4'hC;
    localparam logic [3:0] OP_RRC  = 4'hD;
    localparam logic [3:0] OP_MULL = 4'hE;
    localparam logic [3:0] OP_MULH = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    typedef struct packed {
        logic c;
        logic z;
        logic s;
        logic v;
    } flags_t;

    function automatic logic is_mul_op(input logic [3:0] fsel);
        return (fsel == OP_MULL) || (fsel == OP_MULH);
    endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// Only built when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module seq_alu_mul
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_sum;

    always_comb begin
        prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            prod_d   = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
        end else if (busy_q) begin
            prod_d   = prod_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            // Counter parks on the last iteration instead of wrapping.
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    // The final partial sum is handed out combinationally so the caller can
    // register it on the same edge as the last iteration.
    assign done    = busy_q && (cnt_q == LAST);
    assign product = prod_sum;

endmodule
`endif

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready on both sides. Define ALU_MUL_EN to build
// the multi-cycle MULL/MULH path (seq_alu_mul); otherwise they return zero.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] ABUS,
    input  logic [WIDTH-1:0] BBUS,
    input  logic [3:0]       FSEL,
    input  logic             CIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] FOUT,
    output logic             C,
    output logic             Z,
    output logic             S,
    output logic             V
);

    logic             accept, retire, mul_accept;
    logic [WIDTH:0]   sum_ext, dif_ext, inc_ext, dec_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    flags_t           alu_flags;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] fout_q, fout_d;
    flags_t           flags_q, flags_d;

    assign accept = IN_VALID & IN_READY;
    assign retire = out_valid_q & OUT_READY;

    assign sum_ext = {1'b0, ABUS} + {1'b0, BBUS} + {{WIDTH{1'b0}}, CIN};
    assign dif_ext = {1'b0, ABUS} - {1'b0, BBUS} - {{WIDTH{1'b0}}, CIN};
    assign inc_ext = {1'b0, ABUS} + (WIDTH+1)'(1);
    assign dec_ext = {1'b0, ABUS} - (WIDTH+1)'(1);

    // Unlisted or unknown selects fall into default and produce a zero result.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (FSEL)
            OP_TFR: alu_res = ABUS;
            OP_INC: begin
                alu_res = inc_ext[WIDTH-1:0];
                alu_c   = inc_ext[WIDTH];
                alu_v   = ~ABUS[WIDTH-1] & alu_res[WIDTH-1];
            end
            OP_DEC: begin
                alu_res = dec_ext[WIDTH-1:0];
                alu_c   = dec_ext[WIDTH];
                alu_v   = ABUS[WIDTH-1] & ~alu_res[WIDTH-1];
            end
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (ABUS[WIDTH-1] == BBUS[WIDTH-1]) & (alu_res[WIDTH-1] != ABUS[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif_ext[WIDTH-1:0];
                alu_c   = dif_ext[WIDTH];
                alu_v   = (ABUS[WIDTH-1] != BBUS[WIDTH-1]) & (alu_res[WIDTH-1] != ABUS[WIDTH-1]);
            end
            OP_AND: alu_res = ABUS & BBUS;
            OP_OR:  alu_res = ABUS | BBUS;
            OP_XOR: alu_res = ABUS ^ BBUS;
            OP_NOT: alu_res = ~ABUS;
            OP_SHL: begin
                alu_res = {ABUS[WIDTH-2:0], 1'b0};
                alu_c   = ABUS[WIDTH-1];
                alu_v   = ABUS[WIDTH-1] ^ ABUS[WIDTH-2];
            end
            OP_SHR: begin
                alu_res = {1'b0, ABUS[WIDTH-1:1]};
                alu_c   = ABUS[0];
            end
            OP_ASR: begin
                alu_res = {ABUS[WIDTH-1], ABUS[WIDTH-1:1]};
                alu_c   = ABUS[0];
            end
            OP_RLC: begin
                alu_res = {ABUS[WIDTH-2:0], CIN};
                alu_c   = ABUS[WIDTH-1];
            end
            OP_RRC: begin
                alu_res = {CIN, ABUS[WIDTH-1:1]};
                alu_c   = ABUS[0];
            end
            default: alu_res = '0;
        endcase
        alu_flags.c = alu_c;
        alu_flags.z = (alu_res == '0);
        alu_flags.s = alu_res[WIDTH-1];
        alu_flags.v = alu_v;
    end

`ifdef ALU_MUL_EN
    state_e             state_q, state_d;
    logic               mulh_q, mulh_d;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   mul_res;
    flags_t             mul_flags;

    assign mul_accept = accept & is_mul_op(FSEL);
    assign IN_READY   = (state_q == IDLE) & (~out_valid_q | OUT_READY);

    seq_alu_mul #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (CLK),
        .rst_n   (RST_N),
        .start   (mul_accept),
        .a       (ABUS),
        .b       (BBUS),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        mul_res     = mulh_q ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];
        mul_flags.c = ~mulh_q & (|mul_prod[2*WIDTH-1:WIDTH]);
        mul_flags.v = mul_flags.c;
        mul_flags.z = (mul_res == '0);
        mul_flags.s = mul_res[WIDTH-1];
    end
`else
    assign mul_accept = 1'b0;
    assign IN_READY   = ~out_valid_q | OUT_READY;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        fout_d      = fout_q;
        flags_d     = flags_q;
`ifdef ALU_MUL_EN
        state_d     = state_q;
        mulh_d      = mulh_q;
        if (mul_accept) begin
            state_d = MUL;
            mulh_d  = (FSEL == OP_MULH);
        end
        if (mul_done) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            fout_d      = mul_res;
            flags_d     = mul_flags;
        end
`endif
        if (retire) begin
            out_valid_d = 1'b0;
        end
        // A same-cycle accept overrides the retire so results stream with no bubble.
        if (accept && !mul_accept) begin
            out_valid_d = 1'b1;
            fout_d      = alu_res;
            flags_d     = alu_flags;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid_q <= 1'b0;
            fout_q      <= '0;
            flags_q     <= '0;
`ifdef ALU_MUL_EN
            state_q     <= IDLE;
            mulh_q      <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            fout_q      <= fout_d;
            flags_q     <= flags_d;
`ifdef ALU_MUL_EN
            state_q     <= state_d;
            mulh_q      <= mulh_d;
`endif
        end
    end

    assign OUT_VALID = out_valid_q;
    assign FOUT      = fout_q;
    assign C         = flags_q.c;
    assign Z         = flags_q.z;
    assign S         = flags_q.s;
    assign V         = flags_q.v;

endmodule
